// File: rtl/axis_cfg_sequencer.sv
// Descriptor-to-cfg-bus sequencer: turns each accepted (dir, addr, len) descriptor
// into ADDR, LEN and GO register writes, then holds off for a programmable gap.
module axis_cfg_sequencer #(
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32,
    parameter int CONFIG_ID_WR  = 1,
    parameter int CONFIG_ID_RD  = 2,
    parameter int CONFIG_ADDR   = 23,
    parameter int CONFIG_DATA   = 24,
    parameter int GAP_CYCLES    = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     desc_valid,
    input  logic                     desc_dir,
    input  logic [CONFIG_DWIDTH-1:0] desc_addr,
    input  logic [CONFIG_DWIDTH-1:0] desc_len,
    output logic                     desc_ready,
    output logic [CONFIG_AWIDTH-1:0] cfg_addr,
    output logic [CONFIG_DWIDTH-1:0] cfg_data,
    output logic                     cfg_valid,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     wr_issued,
    output logic [CNT_WIDTH-1:0]     rd_issued,
    output logic                     err_zero_len
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_GO   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

    localparam logic [GAP_W-1:0]         GAP_LOAD  = GAP_LOAD_I[GAP_W-1:0];
    localparam logic [GAP_W-1:0]         GAP_ONE   = GAP_W'(1'b1);
    localparam logic [GAP_W-1:0]         GAP_ZERO  = {GAP_W{1'b0}};
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CONFIG_DWIDTH-1:0] DATA_ZERO = {CONFIG_DWIDTH{1'b0}};
    localparam logic [CONFIG_DWIDTH-1:0] DATA_ONE  = CONFIG_DWIDTH'(1'b1);
    localparam logic [CONFIG_AWIDTH-1:0] AD_ZERO   = {CONFIG_AWIDTH{1'b0}};
    localparam logic [CONFIG_AWIDTH-1:0] AD_ADDR   = CONFIG_AWIDTH'(CONFIG_ADDR);
    localparam logic [CONFIG_AWIDTH-1:0] AD_DATA   = CONFIG_AWIDTH'(CONFIG_DATA);
    localparam logic [CONFIG_AWIDTH-1:0] AD_ID_WR  = CONFIG_AWIDTH'(CONFIG_ID_WR);
    localparam logic [CONFIG_AWIDTH-1:0] AD_ID_RD  = CONFIG_AWIDTH'(CONFIG_ID_RD);

    state_t                     state_r;
    logic                       dir_r;
    logic [CONFIG_DWIDTH-1:0]   len_r;
    logic [GAP_W-1:0]           gap_cnt_r;
    logic                       desc_ready_r;
    logic [CONFIG_AWIDTH-1:0]   cfg_addr_r;
    logic [CONFIG_DWIDTH-1:0]   cfg_data_r;
    logic                       cfg_valid_r;
    logic                       busy_r;
    logic [CNT_WIDTH-1:0]       wr_issued_r;
    logic [CNT_WIDTH-1:0]       rd_issued_r;
    logic                       err_zero_len_r;

    // Sequencer FSM; every output register is loaded with the value of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            dir_r          <= 1'b0;
            len_r          <= DATA_ZERO;
            gap_cnt_r      <= GAP_ZERO;
            desc_ready_r   <= 1'b0;
            cfg_addr_r     <= AD_ZERO;
            cfg_data_r     <= DATA_ZERO;
            cfg_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
            wr_issued_r    <= CNT_ZERO;
            rd_issued_r    <= CNT_ZERO;
            err_zero_len_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (desc_valid && desc_ready_r) begin
                        if (desc_len != DATA_ZERO) begin
                            state_r      <= ST_ADDR;
                            dir_r        <= desc_dir;
                            len_r        <= desc_len;
                            desc_ready_r <= 1'b0;
                            busy_r       <= 1'b1;
                            cfg_valid_r  <= 1'b1;
                            cfg_addr_r   <= AD_ADDR;
                            cfg_data_r   <= desc_addr;
                        end else begin
                            // Zero-length work is dropped without touching the engine.
                            err_zero_len_r <= 1'b1;
                            desc_ready_r   <= 1'b1;
                        end
                    end else begin
                        desc_ready_r <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    state_r    <= ST_LEN;
                    cfg_addr_r <= AD_DATA;
                    cfg_data_r <= len_r;
                end
                ST_LEN: begin
                    state_r    <= ST_GO;
                    cfg_data_r <= DATA_ONE;
                    if (dir_r) begin
                        cfg_addr_r  <= AD_ID_WR;
                        wr_issued_r <= wr_issued_r + CNT_ONE;
                    end else begin
                        cfg_addr_r  <= AD_ID_RD;
                        rd_issued_r <= rd_issued_r + CNT_ONE;
                    end
                end
                ST_GO: begin
                    cfg_valid_r <= 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= GAP_LOAD;
                    end else begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        desc_ready_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_ZERO) begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        desc_ready_r <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_ONE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cfg_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    desc_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign desc_ready   = desc_ready_r;
    assign cfg_addr     = cfg_addr_r;
    assign cfg_data     = cfg_data_r;
    assign cfg_valid    = cfg_valid_r;
    assign busy         = busy_r;
    assign wr_issued    = wr_issued_r;
    assign rd_issued    = rd_issued_r;
    assign err_zero_len = err_zero_len_r;

endmodule

// File: tb/tb_axis_cfg_sequencer.sv
// Directed bench for axis_cfg_sequencer: default build (GAP_CYCLES = 2) plus a
// narrow-counter, zero-gap build for wrap and spacing checks.
module tb_axis_cfg_sequencer;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_dir = 1'b0;
    logic [31:0] desc_addr = 32'd0;
    logic [31:0] desc_len = 32'd0;
    logic        desc_ready;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        busy;
    logic [15:0] wr_issued;
    logic [15:0] rd_issued;
    logic        err_zero_len;

    logic        d2_valid = 1'b0;
    logic        d2_dir = 1'b0;
    logic [31:0] d2_addr = 32'd0;
    logic [31:0] d2_len = 32'd0;
    logic        d2_ready;
    logic [4:0]  d2_cfg_addr;
    logic [31:0] d2_cfg_data;
    logic        d2_cfg_valid;
    logic        d2_busy;
    logic [3:0]  d2_wr;
    logic [3:0]  d2_rd;
    logic        d2_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_cfg_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_dir(desc_dir),
        .desc_addr(desc_addr), .desc_len(desc_len), .desc_ready(desc_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .busy(busy), .wr_issued(wr_issued), .rd_issued(rd_issued),
        .err_zero_len(err_zero_len)
    );

    axis_cfg_sequencer #(.GAP_CYCLES(0), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst),
        .desc_valid(d2_valid), .desc_dir(d2_dir),
        .desc_addr(d2_addr), .desc_len(d2_len), .desc_ready(d2_ready),
        .cfg_addr(d2_cfg_addr), .cfg_data(d2_cfg_data), .cfg_valid(d2_cfg_valid),
        .busy(d2_busy), .wr_issued(d2_wr), .rd_issued(d2_rd),
        .err_zero_len(d2_err)
    );

    typedef struct {
        logic        dir;
        logic [31:0] addr;
        logic [31:0] len;
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one descriptor and follows its ADDR/LEN/GO/GAP sequence cycle by cycle.
    task automatic run_desc(input logic dir, input logic [31:0] addr, input logic [31:0] len,
                            input logic [15:0] ew, input logic [15:0] er);
        int  n;
        logic got;
        logic [31:0] go_a;
        go_a = dir ? 32'd1 : 32'd2;
        @(posedge clk); #1;
        desc_dir = dir; desc_addr = addr; desc_len = len; desc_valid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (desc_ready) got = 1'b1;
        end
        chk("accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        desc_valid = 1'b0;
        @(negedge clk);
        chk("addr_valid", 32'(cfg_valid), 32'd1);
        chk("addr_idx", 32'(cfg_addr), 32'd23);
        chk("addr_data", cfg_data, addr);
        chk("addr_busy", 32'(busy), 32'd1);
        chk("addr_ready", 32'(desc_ready), 32'd0);
        @(negedge clk);
        chk("len_valid", 32'(cfg_valid), 32'd1);
        chk("len_idx", 32'(cfg_addr), 32'd24);
        chk("len_data", cfg_data, len);
        @(negedge clk);
        chk("go_valid", 32'(cfg_valid), 32'd1);
        chk("go_idx", 32'(cfg_addr), go_a);
        chk("go_data", cfg_data, 32'd1);
        chk("wr_issued", 32'(wr_issued), 32'(ew));
        chk("rd_issued", 32'(rd_issued), 32'(er));
        for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            chk("gap_valid", 32'(cfg_valid), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_ready", 32'(desc_ready), 32'd0);
            chk("gap_idx_hold", 32'(cfg_addr), go_a);
        end
        @(negedge clk);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(desc_ready), 32'd1);
        chk("end_valid", 32'(cfg_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic        b_dir[4];
        int          acc;
        int          strobe;
        int          ready_low;
        int          acc_cyc[17];
        int          n;
        logic        hit;
        logic        any_valid;
        logic        any_busy;
        logic        any_nready;
        logic [31:0] ea;
        logic [31:0] ed;

        vecs[0] = '{dir: 1'b1, addr: 32'h1000_0000, len: 32'd64,        exp_wr: 16'd1, exp_rd: 16'd0};
        vecs[1] = '{dir: 1'b0, addr: 32'h0000_2000, len: 32'd8,         exp_wr: 16'd1, exp_rd: 16'd1};
        vecs[2] = '{dir: 1'b1, addr: 32'hFFFF_FFFD, len: 32'hFFFF_FFFF, exp_wr: 16'd2, exp_rd: 16'd1};
        vecs[3] = '{dir: 1'b0, addr: 32'h0000_0003, len: 32'd1,         exp_wr: 16'd2, exp_rd: 16'd2};
        b_dir[0] = 1'b1; b_dir[1] = 1'b0; b_dir[2] = 1'b1; b_dir[3] = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", 32'(cfg_valid), 32'd0);
        chk("rst_addr", 32'(cfg_addr), 32'd0);
        chk("rst_data", cfg_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(desc_ready), 32'd0);
        chk("rst_wr", 32'(wr_issued), 32'd0);
        chk("rst_rd", 32'(rd_issued), 32'd0);
        chk("rst_err", 32'(err_zero_len), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(desc_ready), 32'd1);

        for (int i = 0; i < 4; i++)
            run_desc(vecs[i].dir, vecs[i].addr, vecs[i].len, vecs[i].exp_wr, vecs[i].exp_rd);

        // Back-to-back: valid held high with four queued descriptors
        @(posedge clk); #1;
        acc = 0; strobe = 0; ready_low = 0;
        desc_dir = b_dir[0]; desc_addr = 32'h100; desc_len = 32'd10; desc_valid = 1'b1;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            if (cfg_valid) begin
                if (strobe < 12) begin
                    case (strobe % 3)
                        0: begin ea = 32'd23; ed = 32'h100 * 32'(strobe / 3 + 1); end
                        1: begin ea = 32'd24; ed = 32'd10 + 32'(strobe / 3); end
                        default: begin ea = b_dir[strobe / 3] ? 32'd1 : 32'd2; ed = 32'd1; end
                    endcase
                    chk("b2b_idx", 32'(cfg_addr), ea);
                    chk("b2b_data", cfg_data, ed);
                end
                strobe++;
            end
            hit = desc_valid && desc_ready;
            if (desc_valid && !desc_ready) ready_low++;
            if (hit && acc < 4) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            @(posedge clk); #1;
            if (hit) begin
                if (acc < 4) begin
                    desc_dir = b_dir[acc];
                    desc_addr = 32'h100 * 32'(acc + 1);
                    desc_len = 32'd10 + 32'(acc);
                end else begin
                    desc_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepts", 32'(acc), 32'd4);
        chk("b2b_strobes", 32'(strobe), 32'd12);
        chk("b2b_ready_low", 32'(ready_low), 32'd15);
        for (int i = 1; i < 4; i++)
            if (i < acc) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
        chk("b2b_wr", 32'(wr_issued), 32'd5);
        chk("b2b_rd", 32'(rd_issued), 32'd3);

        // Zero-length descriptor is dropped and flagged
        @(posedge clk); #1;
        desc_dir = 1'b1; desc_addr = 32'hCAFE_0000; desc_len = 32'd0; desc_valid = 1'b1;
        @(negedge clk);
        chk("zl_ready_pre", 32'(desc_ready), 32'd1);
        @(posedge clk); #1;
        desc_valid = 1'b0;
        any_valid = 1'b0; any_busy = 1'b0; any_nready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_valid  = any_valid | cfg_valid;
            any_busy   = any_busy | busy;
            any_nready = any_nready | !desc_ready;
        end
        chk("zl_no_cfg", 32'(any_valid), 32'd0);
        chk("zl_no_busy", 32'(any_busy), 32'd0);
        chk("zl_ready_low", 32'(any_nready), 32'd0);
        chk("zl_err", 32'(err_zero_len), 32'd1);
        chk("zl_wr_same", 32'(wr_issued), 32'd5);
        run_desc(1'b0, 32'h0000_55AA, 32'd5, 16'd5, 16'd4);
        chk("zl_err_sticky", 32'(err_zero_len), 32'd1);

        // Reset asserted during the LEN write
        @(posedge clk); #1;
        desc_dir = 1'b1; desc_addr = 32'hDEAD_0000; desc_len = 32'd7; desc_valid = 1'b1;
        n = 0;
        while (!desc_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        desc_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_len_valid", 32'(cfg_valid), 32'd1);
        chk("mid_len_idx", 32'(cfg_addr), 32'd24);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(cfg_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wr", 32'(wr_issued), 32'd0);
        chk("mid_rst_rd", 32'(rd_issued), 32'd0);
        chk("mid_rst_ready", 32'(desc_ready), 32'd0);
        chk("mid_rst_err", 32'(err_zero_len), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        any_valid = 1'b0; any_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any_valid = any_valid | cfg_valid;
            any_busy  = any_busy | busy;
        end
        chk("no_resume_cfg", 32'(any_valid), 32'd0);
        chk("no_resume_busy", 32'(any_busy), 32'd0);
        run_desc(1'b1, 32'h0000_ABC0, 32'd3, 16'd1, 16'd0);

        // Narrow counters, zero gap: 17 writes wrap to 1, acceptances 4 cycles apart
        @(posedge clk); #1;
        acc = 0; strobe = 0;
        d2_dir = 1'b1; d2_addr = 32'd0; d2_len = 32'd1; d2_valid = 1'b1;
        for (int cyc = 1; cyc <= 200 && acc < 17; cyc++) begin
            @(negedge clk);
            if (d2_cfg_valid) strobe++;
            hit = d2_valid && d2_ready;
            if (hit) begin
                acc_cyc[acc] = cyc;
                if (acc > 0) chk("gap0_spacing", 32'(acc_cyc[acc] - acc_cyc[acc-1]), 32'd4);
                acc++;
            end
            @(posedge clk); #1;
            if (hit) begin
                d2_addr = 32'(acc) * 32'h10;
                d2_len = 32'(acc) + 32'd1;
                if (acc == 17) d2_valid = 1'b0;
            end
        end
        chk("gap0_accepts", 32'(acc), 32'd17);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (d2_cfg_valid) strobe++;
        end
        chk("gap0_strobes", 32'(strobe), 32'd51);
        chk("wrap_wr", 32'(d2_wr), 32'd1);
        chk("wrap_rd", 32'(d2_rd), 32'd0);
        chk("gap0_idle", 32'(d2_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_cfg_sequencer.md
Name: axis_cfg_sequencer

Overview:
- Upstream neighbour of the AXI stream engine. Accepts transfer descriptors (direction, start address, length) over a valid/ready handshake.
- Serialises each descriptor into three single-cycle writes on the engine's configuration bus (cfg_addr/cfg_data/cfg_valid).
- Enforces a programmable idle gap between descriptors and counts issued transfers per direction, so software or a test master can queue work without driving the cfg bus directly.

Parameters:
- CONFIG_AWIDTH, 5, width of cfg_addr.
- CONFIG_DWIDTH, 32, width of cfg_data, desc_addr and desc_len.
- CONFIG_ID_WR, 1, cfg register index for the write-engine "go" command.
- CONFIG_ID_RD, 2, cfg register index for the read-engine "go" command.
- CONFIG_ADDR, 23, cfg register index for the start address.
- CONFIG_DATA, 24, cfg register index for the transfer length.
- GAP_CYCLES, 2, idle cycles forced after each "go" write (0 allowed).
- CNT_WIDTH, 16, width of the per-direction issue counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor valid.
- desc_dir  in  1  direction: 1 = write engine, 0 = read engine.
- desc_addr  in  CONFIG_DWIDTH  start byte address.
- desc_len  in  CONFIG_DWIDTH  transfer length in stream words.
- desc_ready  out  1  descriptor accepted when desc_valid and desc_ready are both high.
- cfg_addr  out  CONFIG_AWIDTH  cfg register index.
- cfg_data  out  CONFIG_DWIDTH  cfg write data.
- cfg_valid  out  1  one-cycle cfg write strobe.
- busy  out  1  high whenever the FSM is not in IDLE.
- wr_issued  out  CNT_WIDTH  count of completed write-direction "go" writes.
- rd_issued  out  CNT_WIDTH  count of completed read-direction "go" writes.
- err_zero_len  out  1  sticky flag: a descriptor with desc_len = 0 was dropped.

Behaviour:
Reset (rst low, asynchronous):
- FSM goes to IDLE.
- cfg_valid = 0, cfg_addr = 0, cfg_data = 0, busy = 0, wr_issued = 0, rd_issued = 0, err_zero_len = 0.
- desc_ready = 0 while rst is low; desc_ready = 1 on the first clock edge after release.

Outputs and latching:
- All outputs are registered.
- On acceptance, desc_dir/addr/len are latched into an internal holding register. The inputs are not sampled again until the next acceptance.

FSM states: IDLE, ADDR, LEN, GO, GAP.
- IDLE:
  - desc_ready = 1.
  - Accept with desc_len != 0 -> ADDR.
  - Accept with desc_len == 0 -> stay in IDLE, set err_zero_len, emit no cfg writes.
- ADDR: cfg_valid = 1, cfg_addr = CONFIG_ADDR, cfg_data = latched address -> LEN.
- LEN: cfg_valid = 1, cfg_addr = CONFIG_DATA, cfg_data = latched length -> GO.
- GO:
  - cfg_valid = 1, cfg_addr = CONFIG_ID_WR if dir = 1 else CONFIG_ID_RD, cfg_data = 1.
  - Increment the matching counter in this same cycle.
  - -> GAP if GAP_CYCLES > 0, else -> IDLE.
- GAP:
  - cfg_valid = 0, cfg_addr and cfg_data hold their last values.
  - Down-counter loaded with GAP_CYCLES-1 on entry; -> IDLE when it reaches 0.

Handshake and timing:
- desc_ready = 0 in every state except IDLE. There is no skid buffer, so peak throughput is one descriptor per 3 + GAP_CYCLES + 1 cycles.
- Latency: acceptance edge -> cfg_valid high on the next cycle (ADDR). Three back-to-back cfg strobes follow, in the order ADDR, LEN, GO.
- cfg_valid is never high for two cycles with the same cfg_addr.
- cfg_addr and cfg_data are stable only while cfg_valid = 1.
- busy = 1 in ADDR, LEN, GO and GAP.

Counters and flags:
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- err_zero_len is cleared only by reset.

Boundary conditions:
- desc_valid held high continuously: the next descriptor is accepted on the first IDLE cycle.
- Reset asserted mid-sequence: the sequence is aborted immediately, cfg_valid drops asynchronously, and no partial descriptor is resumed after release.
- desc_addr and desc_len are passed unmodified; there is no alignment checking.

Test Plan:
1. Reset, then one descriptor (dir = 1, addr = 0x1000_0000, len = 64) -> cfg writes (23, 0x1000_0000), (24, 64), (1, 1) on 3 consecutive cycles starting 1 cycle after acceptance; wr_issued = 1; busy falls 3 + GAP_CYCLES cycles after the first cfg_valid.
2. Read descriptor (dir = 0, addr = 0x2000, len = 8) -> GO write uses cfg_addr = 2; rd_issued = 1; wr_issued unchanged.
3. desc_valid held high with 4 descriptors queued (GAP_CYCLES = 2) -> acceptances exactly 6 cycles apart; 12 cfg strobes in ADDR/LEN/GO order; desc_ready low between acceptances.
4. Descriptor with len = 0 -> no cfg_valid pulse; err_zero_len = 1 and stays 1; desc_ready stays 1; the following valid descriptor is processed normally.
5. Assert rst in the cycle of the LEN write -> cfg_valid = 0 and busy = 0 immediately; counters = 0; after release, a new descriptor starts cleanly with ADDR.
6. CNT_WIDTH = 4, issue 17 write descriptors -> wr_issued = 1 (wrapped); GAP_CYCLES = 0 build gives a 4-cycle acceptance spacing.
